// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store size encodings and the default bus timeout.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for one access: byte enables, replicated store data,
// extended load data and the size/alignment legality check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        illegal
);

  logic [31:0] lane;

  always_comb begin
    lane      = rdata >> {addr, 3'b000};
    be        = 4'b0000;
    wdata_rep = '0;
    rdata_ext = '0;
    unique case (funct3)
      F3_LB: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{lane[7]}}, lane[7:0]};
      end
      F3_LBU: begin
        be        = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h0, lane[7:0]};
      end
      F3_LH: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{lane[15]}}, lane[15:0]};
      end
      F3_LHU: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'h0, lane[15:0]};
      end
      F3_LW: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = '0;
        rdata_ext = '0;
      end
    endcase
    // Unknown encodings, odd halfword or unaligned word addresses.
    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
              (funct3[1:0] == 2'b01 && addr[0]) ||
              (funct3[1:0] == 2'b10 && addr != 2'b00);
  end

endmodule

// File: rtl/load_store_unit.sv
// Turns one datapath load/store into a req/gnt/rvalid bus transaction and
// stalls the pipeline until the response, an error or a timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsu_valid,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_wdata,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_stall,
  output logic              lsu_done,
  output logic              lsu_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e        state;
  logic [CW-1:0]     cnt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [2:0]        sel_f3;
  logic [1:0]        sel_addr;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] rdata_ext;
  logic              illegal;
  logic              bad_op;
  logic              in_req;

  // In IDLE the aligner checks the incoming op; afterwards it works from the captured copy.
  assign sel_f3   = (state == S_IDLE) ? lsu_funct3    : f3_q;
  assign sel_addr = (state == S_IDLE) ? lsu_addr[1:0] : addr_q[1:0];
  assign bad_op   = illegal || (lsu_we && lsu_funct3[2]);

  lsu_align u_align (
    .funct3    (sel_f3),
    .addr      (sel_addr),
    .wdata     (wdata_q),
    .rdata     (bus_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata_ext (rdata_ext),
    .illegal   (illegal)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (lsu_valid) begin
            we_q    <= lsu_we;
            f3_q    <= lsu_funct3;
            addr_q  <= lsu_addr;
            wdata_q <= lsu_wdata;
            rdata_q <= '0;
            err_q   <= bad_op;
            state   <= bad_op ? S_DONE : S_REQ;
          end
        end
        S_REQ, S_RESP: begin
          // A response can arrive together with the grant; it wins over a timeout.
          if (bus_rvalid && (state == S_RESP || bus_gnt)) begin
            rdata_q <= we_q ? '0 : rdata_ext;
            err_q   <= bus_err;
            state   <= S_DONE;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
            if (state == S_REQ && bus_gnt) state <= S_RESP;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_req    = (state == S_REQ);
  assign bus_req   = in_req;
  assign bus_we    = in_req && we_q;
  assign bus_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus_be    = in_req ? be : 4'b0000;
  assign bus_wdata = in_req ? wdata_rep : '0;

  assign lsu_stall = (reset && state == S_IDLE && lsu_valid) ||
                     (state == S_REQ) || (state == S_RESP);
  assign lsu_done  = (state == S_DONE);
  assign lsu_err   = lsu_done && err_q;
  assign lsu_rdata = lsu_done ? rdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: cycle-exact handshakes, lane steering,
// error paths, timeout and asynchronous reset mid-transaction.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        lsu_valid, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_stall, lsu_done, lsu_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .lsu_valid(lsu_valid), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata),
    .lsu_stall(lsu_stall), .lsu_done(lsu_done), .lsu_err(lsu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  // Presents an op in c0, grants in c1, responds in c2 and waits (bounded) for done.
  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] resp, input logic rerr,
                        output logic [3:0] be_s, output logic [31:0] wd_s,
                        output logic [31:0] rd, output logic er, output bit got);
    got = 1'b0; rd = '0; er = 1'b0;
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
    @(negedge clk);
    lsu_valid = 1'b0; bus_gnt = 1'b1;
    #1; be_s = bus_be; wd_s = bus_wdata;
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = resp; bus_err = rerr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus_rvalid = 1'b0; bus_err = 1'b0;
      #1;
      if (lsu_done) begin
        rd = lsu_rdata; er = lsu_err; got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010;
    lsu_addr = 32'h100; lsu_wdata = 32'hFFFF_FFFF;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF; bus_err = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (lsu_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", lsu_stall); end
    n_cmp++; if ({lsu_done, lsu_err} !== 2'b00) begin n_bad++; $display("FAIL reset_done_err: got %b want 00", {lsu_done, lsu_err}); end
    n_cmp++; if (lsu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", lsu_rdata); end
    n_cmp++; if ({bus_req, bus_we, bus_be} !== 6'b0) begin n_bad++; $display("FAIL reset_bus_ctl: got %b want 0", {bus_req, bus_we, bus_be}); end
    n_cmp++; if ({bus_addr, bus_wdata} !== 64'h0) begin n_bad++; $display("FAIL reset_bus_data: got %h want 0", {bus_addr, bus_wdata}); end
    lsu_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_lw_latency();
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h100; lsu_wdata = '0;
    #1;
    n_cmp++; if ({lsu_stall, bus_req} !== 2'b10) begin n_bad++; $display("FAIL lw_c0: stall/req got %b want 10", {lsu_stall, bus_req}); end
    @(negedge clk);
    lsu_valid = 1'b0; bus_gnt = 1'b1;
    #1;
    n_cmp++; if ({lsu_stall, bus_req, bus_we} !== 3'b110) begin n_bad++; $display("FAIL lw_c1_ctl: got %b want 110", {lsu_stall, bus_req, bus_we}); end
    n_cmp++; if (bus_addr !== 32'h100) begin n_bad++; $display("FAIL lw_c1_addr: got %h want 00000100", bus_addr); end
    n_cmp++; if (bus_be !== 4'b1111) begin n_bad++; $display("FAIL lw_c1_be: got %b want 1111", bus_be); end
    @(negedge clk);
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if ({lsu_stall, bus_req, lsu_done} !== 3'b100) begin n_bad++; $display("FAIL lw_c2: stall/req/done got %b want 100", {lsu_stall, bus_req, lsu_done}); end
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = '0;
    #1;
    n_cmp++; if ({lsu_done, lsu_err, lsu_stall} !== 3'b100) begin n_bad++; $display("FAIL lw_c3: done/err/stall got %b want 100", {lsu_done, lsu_err, lsu_stall}); end
    n_cmp++; if (lsu_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want deadbeef", lsu_rdata); end
    @(negedge clk);
    #1;
    n_cmp++; if (lsu_done !== 1'b0) begin n_bad++; $display("FAIL lw_c4_done: got %b want 0", lsu_done); end
  endtask

  task automatic test_byte_half();
    logic [3:0] be_s; logic [31:0] wd_s, rd; logic er; bit got;
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_FF7F, 1'b0, be_s, wd_s, rd, er, got);
    n_cmp++; if (be_s !== 4'b1000) begin n_bad++; $display("FAIL lb_be: got %b want 1000", be_s); end
    n_cmp++; if ({got, er, rd} !== {2'b10, 32'hFFFF_FF80}) begin n_bad++; $display("FAIL lb_result: got done=%b err=%b %h want 1 0 ffffff80", got, er, rd); end
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_FF7F, 1'b0, be_s, wd_s, rd, er, got);
    n_cmp++; if (be_s !== 4'b1000) begin n_bad++; $display("FAIL lbu_be: got %b want 1000", be_s); end
    n_cmp++; if ({got, er, rd} !== {2'b10, 32'h0000_0080}) begin n_bad++; $display("FAIL lbu_result: got done=%b err=%b %h want 1 0 00000080", got, er, rd); end
    run_op(1'b0, 3'b101, 32'h002, 32'h0, 32'hF00D_1234, 1'b0, be_s, wd_s, rd, er, got);
    n_cmp++; if ({be_s, rd} !== {4'b1100, 32'h0000_F00D}) begin n_bad++; $display("FAIL lhu: got be=%b %h want 1100 0000f00d", be_s, rd); end
    run_op(1'b0, 3'b001, 32'h000, 32'h0, 32'h1234_8001, 1'b0, be_s, wd_s, rd, er, got);
    n_cmp++; if ({be_s, rd} !== {4'b0011, 32'hFFFF_8001}) begin n_bad++; $display("FAIL lh: got be=%b %h want 0011 ffff8001", be_s, rd); end
    run_op(1'b1, 3'b000, 32'h001, 32'h0000_00A5, 32'h7777_7777, 1'b0, be_s, wd_s, rd, er, got);
    n_cmp++; if ({be_s, wd_s} !== {4'b0010, 32'hA5A5_A5A5}) begin n_bad++; $display("FAIL sb_bus: got be=%b %h want 0010 a5a5a5a5", be_s, wd_s); end
    n_cmp++; if ({got, er, rd} !== {2'b10, 32'h0}) begin n_bad++; $display("FAIL sb_result: got done=%b err=%b %h want 1 0 0", got, er, rd); end
  endtask

  task automatic test_sh_held();
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'b001; lsu_addr = 32'h202; lsu_wdata = 32'h1234_ABCD;
    @(negedge clk);
    lsu_valid = 1'b0; lsu_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus_gnt = 1'b1;
      #1;
      n_cmp++;
      if ({bus_req, bus_we, bus_be, bus_addr, bus_wdata} !== {2'b11, 4'b1100, 32'h200, 32'hABCD_ABCD}) begin
        n_bad++; $display("FAIL sh_req_cycle%0d: got req=%b we=%b be=%b a=%h d=%h want 1 1 1100 00000200 abcdabcd",
                          i, bus_req, bus_we, bus_be, bus_addr, bus_wdata);
      end
      @(negedge clk);
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    n_cmp++; if ({lsu_done, lsu_err, lsu_rdata} !== {2'b10, 32'h0}) begin n_bad++; $display("FAIL sh_done: got done=%b err=%b %h want 1 0 0", lsu_done, lsu_err, lsu_rdata); end
  endtask

  task automatic test_illegal();
    logic [2:0]  f3s [3] = '{3'b010, 3'b011, 3'b100};
    logic [31:0] ads [3] = '{32'h101, 32'h100, 32'h100};
    logic        wes [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      lsu_valid = 1'b1; lsu_we = wes[k]; lsu_funct3 = f3s[k]; lsu_addr = ads[k];
      #1;
      n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL illegal%0d_c0_req: got %b want 0", k, bus_req); end
      @(negedge clk);
      lsu_valid = 1'b0;
      #1;
      n_cmp++; if ({bus_req, lsu_done, lsu_err, lsu_stall, lsu_rdata} !== {4'b0110, 32'h0}) begin
        n_bad++; $display("FAIL illegal%0d_c1: got req=%b done=%b err=%b stall=%b %h want 0 1 1 0 0", k, bus_req, lsu_done, lsu_err, lsu_stall, lsu_rdata);
      end
    end
  endtask

  task automatic test_errors();
    logic [3:0] be_s; logic [31:0] wd_s, rd; logic er; bit got; int req_cycles;
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, 1'b1, be_s, wd_s, rd, er, got);
    n_cmp++; if ({got, er} !== 2'b11) begin n_bad++; $display("FAIL bus_err: got done=%b err=%b want 1 1", got, er); end
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h400;
    @(negedge clk);
    lsu_valid = 1'b0;
    req_cycles = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (bus_req) req_cycles++;
      if (lsu_done) begin
        got = 1'b1;
        n_cmp++; if ({bus_req, lsu_err, lsu_rdata} !== {2'b01, 32'h0}) begin n_bad++; $display("FAIL timeout_done: got req=%b err=%b %h want 0 1 0", bus_req, lsu_err, lsu_rdata); end
        break;
      end
      @(negedge clk);
    end
    n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL timeout_seen: got %b want 1", got); end
    n_cmp++; if (req_cycles !== 8) begin n_bad++; $display("FAIL timeout_req_cycles: got %0d want 8", req_cycles); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] be_s; logic [31:0] wd_s, rd; logic er; bit got;
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h40;
    @(negedge clk);
    lsu_valid = 1'b0;
    #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_bad++; $display("FAIL rst_req_before: got %b want 1", bus_req); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({bus_req, lsu_stall, lsu_done} !== 3'b000) begin n_bad++; $display("FAIL rst_in_req: got %b want 000", {bus_req, lsu_stall, lsu_done}); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    lsu_valid = 1'b1; lsu_addr = 32'h40;
    @(negedge clk);
    lsu_valid = 1'b0; bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    n_cmp++; if (lsu_stall !== 1'b1) begin n_bad++; $display("FAIL rst_resp_before: stall got %b want 1", lsu_stall); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({bus_req, lsu_stall, lsu_done} !== 3'b000) begin n_bad++; $display("FAIL rst_in_resp: got %b want 000", {bus_req, lsu_stall, lsu_done}); end
    @(negedge clk); reset = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1;
    n_cmp++; if ({lsu_done, lsu_stall, lsu_rdata} !== {2'b00, 32'h0}) begin n_bad++; $display("FAIL stale_rvalid: got done=%b stall=%b %h want 0 0 0", lsu_done, lsu_stall, lsu_rdata); end
    run_op(1'b0, 3'b010, 32'h44, 32'h0, 32'h0BAD_F00D, 1'b0, be_s, wd_s, rd, er, got);
    n_cmp++; if ({got, er, rd} !== {2'b10, 32'h0BAD_F00D}) begin n_bad++; $display("FAIL post_reset_lw: got done=%b err=%b %h want 1 0 0badf00d", got, er, rd); end
  endtask

  initial begin
    test_reset();
    test_lw_latency();
    test_byte_half();
    test_sh_held();
    test_illegal();
    test_errors();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
